// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// Optional macro REGFILE_BYPASS_EN (used in regfile_mp) enables write-to-read forwarding.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 32;
    localparam int NUM_RD     = 4;
    localparam int NUM_WR     = 2;
    localparam int AW         = $clog2(DEPTH);

    typedef logic [AW-1:0]         reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_wr_sel.sv
// Write-port selector: reports whether any enabled write port targets addr and
// returns that port's data, with the highest-index port taking priority.
module regfile_wr_sel #(
    parameter int NUM_WR     = regfile_pkg::NUM_WR,
    parameter int AW         = regfile_pkg::AW,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
    input  logic [AW-1:0]                addr,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*AW-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic                         hit,
    output logic [DATA_WIDTH-1:0]        data
);

    // NOTE: blocking assignments in always_comb; the ascending scan lets a later
    // (higher-index) port overwrite an earlier match, which is the priority rule.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard (set at issue, cleared at writeback).
// Define REGFILE_BYPASS_EN to forward same-cycle write data and post-edge busy onto the read ports.
module regfile_mp #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int DEPTH      = regfile_pkg::DEPTH,
    parameter int NUM_RD     = regfile_pkg::NUM_RD,
    parameter int NUM_WR     = regfile_pkg::NUM_WR,
    parameter int ZERO_REG   = 1,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*AW-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_WR-1:0]            sb_set_en,
    input  logic [NUM_WR*AW-1:0]         sb_set_addr,
    output logic [DEPTH-1:0]             busy_vec
);

    import regfile_pkg::*;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem         [DEPTH];
    logic [DATA_WIDTH-1:0] wr_sel_data [DEPTH];
    logic [DEPTH-1:0]      busy, busy_nxt, set_vec, wr_hit, wr_we;

    // Out-of-range addresses never match a register index, so they drop out here.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        regfile_wr_sel #(.NUM_WR(NUM_WR), .AW(AW), .DATA_WIDTH(DATA_WIDTH)) u_wr_sel (
            .addr    (AW'(r)),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (wr_hit[r]),
            .data    (wr_sel_data[r])
        );
        assign wr_we[r] = wr_hit[r] && !((ZERO_REG != 0) && (r == 0));
    end

    always_comb begin
        set_vec = '0;
        for (int s = 0; s < NUM_WR; s++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (sb_set_en[s] && (sb_set_addr[s*AW +: AW] == AW'(r))) set_vec[r] = 1'b1;
            end
        end
        if (ZERO_REG != 0) set_vec[0] = 1'b0;
    end

    // A new producer supersedes the retiring one, so set beats writeback clear.
    assign busy_nxt = set_vec | (busy & ~wr_hit);

    // NOTE: the storage array is reset explicitly because the architectural state
    // must read zero after reset; sequential state uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            busy <= busy_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_we[i]) mem[i] <= wr_sel_data[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [NUM_RD-1:0]     byp_hit;
    logic [DATA_WIDTH-1:0] byp_data [NUM_RD];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_byp
        regfile_wr_sel #(.NUM_WR(NUM_WR), .AW(AW), .DATA_WIDTH(DATA_WIDTH)) u_byp_sel (
            .addr    (rd_addr[p*AW +: AW]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (byp_hit[p]),
            .data    (byp_data[p])
        );
    end
`endif

    always_comb begin
        logic [AW-1:0] a;
        logic          valid;
        a       = '0;
        valid   = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            a     = rd_addr[p*AW +: AW];
            valid = ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == AW'(ZERO_ADDR)));
            if (valid) begin
                rd_data[p*DATA_WIDTH +: DATA_WIDTH] = mem[a];
                rd_busy[p]                          = busy[a];
`ifdef REGFILE_BYPASS_EN
                // Forwarding is suppressed while reset holds the state at zero.
                if (rst && byp_hit[p]) begin
                    rd_data[p*DATA_WIDTH +: DATA_WIDTH] = byp_data[p];
                    rd_busy[p]                          = set_vec[a];
                end
`endif
            end
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: architectural model plus directed vectors.
// Works with or without REGFILE_BYPASS_EN defined.
module tb_regfile_mp;
    import regfile_pkg::*;

    // Non-power-of-two depth so addresses 24..31 exercise the out-of-range rules.
    localparam int DW  = 32;
    localparam int DEP = 24;
    localparam int NRD = 4;
    localparam int NWR = 2;
    localparam int AWT = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NRD*AWT-1:0]   rd_addr = '0;
    logic [NRD*DW-1:0]    rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en = '0;
    logic [NWR*AWT-1:0]   wr_addr = '0;
    logic [NWR*DW-1:0]    wr_data = '0;
    logic [NWR-1:0]       sb_set_en = '0;
    logic [NWR*AWT-1:0]   sb_set_addr = '0;
    logic [DEP-1:0]       busy_vec;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_WIDTH(DW), .DEPTH(DEP), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(busy_vec)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic started  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Architectural model: what each register holds and which are awaiting a producer.
    reg_data_t      m_mem [DEP];
    logic [DEP-1:0] m_busy;

    function automatic bit addr_ok(input int a);
        return (a < DEP) && (a != 0);
    endfunction

    always @(negedge rst) begin
        for (int i = 0; i < DEP; i++) m_mem[i] = '0;
        m_busy = '0;
    end

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && addr_ok(int'(wr_addr[w*AWT +: AWT])))
                    m_mem[wr_addr[w*AWT +: AWT]] = wr_data[w*DW +: DW];
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && addr_ok(int'(wr_addr[w*AWT +: AWT]))) m_busy[wr_addr[w*AWT +: AWT]] = 1'b0;
            for (int s = 0; s < NWR; s++)
                if (sb_set_en[s] && addr_ok(int'(sb_set_addr[s*AWT +: AWT]))) m_busy[sb_set_addr[s*AWT +: AWT]] = 1'b1;
        end
    end

    function automatic void expect_rd(input int p, output reg_data_t d, output logic b);
        int a;
        a = int'(rd_addr[p*AWT +: AWT]);
        d = '0;
        b = 1'b0;
        if (rst !== 1'b1 || !addr_ok(a)) return;
        d = m_mem[a];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && int'(wr_addr[w*AWT +: AWT]) == a) begin
                d = wr_data[w*DW +: DW];
                b = 1'b0;
                for (int s = 0; s < NWR; s++)
                    if (sb_set_en[s] && int'(sb_set_addr[s*AWT +: AWT]) == a) b = 1'b1;
            end
        end
`endif
    endfunction

    always @(negedge clk) begin
        if (started) begin
            reg_data_t ed;
            logic      eb;
            for (int p = 0; p < NRD; p++) begin
                expect_rd(p, ed, eb);
                check($sformatf("model rd_data[%0d]", p), 64'(rd_data[p*DW +: DW]), 64'(ed));
                check($sformatf("model rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(eb));
            end
            check("model busy_vec", 64'(busy_vec), 64'(m_busy));
        end
    end

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AWT +: AWT] = AWT'(a);
    endtask

    task automatic set_wr(input int w, input int a, input logic [DW-1:0] d);
        wr_en[w] = 1'b1;
        wr_addr[w*AWT +: AWT] = AWT'(a);
        wr_data[w*DW +: DW] = d;
    endtask

    task automatic set_sb(input int s, input int a);
        sb_set_en[s] = 1'b1;
        sb_set_addr[s*AWT +: AWT] = AWT'(a);
    endtask

    task automatic clear_en();
        wr_en     = '0;
        sb_set_en = '0;
    endtask

    // One clock: commit at the edge, drop enables, let reads settle.
    task automatic step();
        @(posedge clk);
        #1 clear_en();
        #1;
    endtask

    function automatic logic [DW-1:0] rdp(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    initial begin
        #2 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        started = 1'b1;

        // Reset state on every address, including out-of-range ones.
        for (int a = 0; a < 32; a += 4) begin
            for (int p = 0; p < NRD; p++) set_rd(p, a + p);
            #1;
            for (int p = 0; p < NRD; p++) begin
                check($sformatf("reset rd_data a=%0d", a + p), 64'(rdp(p)), 64'h0);
                check($sformatf("reset rd_busy a=%0d", a + p), 64'(rd_busy[p]), 64'h0);
            end
            step();
        end
        check("reset busy_vec", 64'(busy_vec), 64'h0);

        // Write-write collision: port 1 wins.
        set_wr(0, 5, 32'hAAAA_0001);
        set_wr(1, 5, 32'h5555_0002);
        set_rd(0, 5);
        step();
        check("collision addr5", 64'(rdp(0)), 64'h5555_0002);

        // Zero register ignores writes and sets.
        set_wr(0, 0, 32'hDEAD_BEEF);
        set_sb(0, 0);
        set_rd(1, 0);
        step();
        check("zero reg data", 64'(rdp(1)), 64'h0);
        check("zero reg busy_vec[0]", 64'(busy_vec[0]), 64'h0);

        // Busy set, held, set-beats-clear, then writeback clear.
        set_sb(1, 7);
        set_rd(2, 7);
        step();
        repeat (3) step();
        check("busy7 held", 64'(rd_busy[2]), 64'h1);
        set_wr(0, 7, 32'h0000_1234);
        set_sb(1, 7);
        step();
        check("busy7 set wins", 64'(rd_busy[2]), 64'h1);
        check("data7 written", 64'(rdp(2)), 64'h1234);
        set_wr(1, 7, 32'h0000_5678);
        step();
        check("busy7 cleared", 64'(rd_busy[2]), 64'h0);
        check("data7 rewritten", 64'(rdp(2)), 64'h5678);

        // Duplicate sets to one address; lower-index write to another address.
        set_sb(0, 12);
        set_sb(1, 12);
        step();
        check("dual set busy_vec", 64'(busy_vec), 64'h1000);
        set_wr(0, 12, 32'h0C0C_0C0C);
        set_wr(1, 13, 32'h0D0D_0D0D);
        set_rd(0, 12);
        set_rd(1, 13);
        step();
        check("busy12 cleared", 64'(busy_vec), 64'h0);
        check("port0 write addr12", 64'(rdp(0)), 64'h0C0C_0C0C);
        check("port1 write addr13", 64'(rdp(1)), 64'h0D0D_0D0D);

        // Out-of-range write and set are ignored; read returns zero.
        set_wr(0, 26, 32'h0000_0077);
        set_sb(1, 26);
        set_rd(3, 26);
        #1;
        check("oor rd_data same cycle", 64'(rdp(3)), 64'h0);
        step();
        check("oor rd_data", 64'(rdp(3)), 64'h0);
        check("oor busy_vec", 64'(busy_vec), 64'h0);

        // Same-cycle read of a register being written.
        set_wr(0, 3, 32'h0000_1111);
        set_sb(0, 3);
        step();
        set_wr(1, 3, 32'h0000_CAFE);
        set_rd(0, 3);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass data", 64'(rdp(0)), 64'hCAFE);
        check("bypass busy", 64'(rd_busy[0]), 64'h0);
`else
        check("no-bypass data", 64'(rdp(0)), 64'h1111);
        check("no-bypass busy", 64'(rd_busy[0]), 64'h1);
`endif
        step();
        check("addr3 after edge", 64'(rdp(0)), 64'hCAFE);
        check("busy3 after edge", 64'(rd_busy[0]), 64'h0);

        // Mixed traffic checked by the model every cycle.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) set_wr(0, (i * 5) % 32, 32'h1000_0000 + i);
            if (i % 3 != 0) set_wr(1, (i * 7 + 1) % 32, 32'hA000_0000 ^ (i << 8));
            if (i % 4 == 1) set_sb(0, (i * 3) % 32);
            if (i % 5 == 2) set_sb(1, (i * 5) % 32);
            for (int p = 0; p < NRD; p++) set_rd(p, (i * 5 + p * 9) % 32);
            step();
        end

        // Reset mid-operation drops the in-flight write.
        set_wr(0, 9, 32'hFFFF_FFFF);
        set_rd(1, 9);
        step();
        check("addr9 written", 64'(rdp(1)), 64'hFFFF_FFFF);
        set_wr(0, 9, 32'h0000_0BAD);
        set_sb(1, 9);
        #1 rst = 1'b0;
        #1;
        check("mid reset rd_data", 64'(rdp(1)), 64'h0);
        check("mid reset busy_vec", 64'(busy_vec), 64'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        clear_en();
        #1;
        check("after reset addr9", 64'(rdp(1)), 64'h0);
        step();
        check("pending write dropped", 64'(rdp(1)), 64'h0);
        check("pending set dropped", 64'(busy_vec), 64'h0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
